// File: rtl/game_pkg.sv
// Shared game types: turn FSM state encoding and the default turn limit.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TURN = 3'd1,
    ST_AUTO = 3'd2,
    ST_DONE = 3'd3
  } state_t;

  localparam int MAX_TURNS_DEFAULT = 9;

  function automatic logic [3:0] sat_inc(input logic [3:0] c, input logic [3:0] lim);
    return (c >= lim) ? lim : c + 4'd1;
  endfunction

endpackage

// File: rtl/turn_ctrl.sv
// Turn sequencer: IDLE/TURN/AUTO/DONE, AUTO only with TURN_CTRL_AUTO_MOVE_EN (else timeout forfeits the turn).
// All outputs registered, one-edge latency; auto_req is held until auto_ack is sampled.
module turn_ctrl
  import game_pkg::*;
#(
  parameter int MAX_TURNS = MAX_TURNS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic       game_over,
  input  logic       timeout,
  input  logic       auto_ack,
  output logic       timer_restart,
  output logic       auto_req,
  output logic       player,
  output logic [3:0] turn_cnt,
  output logic [2:0] state_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_TURNS);

  state_t     state;
  logic       turn_done;
  logic [3:0] next_cnt;

  assign state_o  = state;
  assign next_cnt = sat_inc(turn_cnt, MAX_CNT);

  // A turn completes on a player move, or on the auto-move ack; game_over overrides both.
  always_comb begin
    turn_done = 1'b0;
    if (!game_over) begin
      case (state)
        ST_TURN: turn_done = move_valid;
`ifdef TURN_CTRL_AUTO_MOVE_EN
        ST_AUTO: turn_done = auto_ack;
`endif
        default: turn_done = 1'b0;
      endcase
    end
  end

`ifndef TURN_CTRL_AUTO_MOVE_EN
  logic unused_ack;
  assign unused_ack = auto_ack;
  assign auto_req   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      player        <= 1'b0;
      turn_cnt      <= 4'd0;
      timer_restart <= 1'b0;
`ifdef TURN_CTRL_AUTO_MOVE_EN
      auto_req      <= 1'b0;
`endif
    end else begin
      timer_restart <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_TURN;
            player        <= 1'b0;
            turn_cnt      <= 4'd0;
            timer_restart <= 1'b1;
          end
        end
        ST_TURN: begin
          if (game_over) begin
            state <= ST_DONE;
          end else if (timeout && !move_valid) begin
`ifdef TURN_CTRL_AUTO_MOVE_EN
            state    <= ST_AUTO;
            auto_req <= 1'b1;
`else
            player        <= ~player;
            timer_restart <= 1'b1;
`endif
          end
        end
`ifdef TURN_CTRL_AUTO_MOVE_EN
        ST_AUTO: begin
          if (game_over) begin
            state    <= ST_DONE;
            auto_req <= 1'b0;
          end else if (auto_ack) begin
            auto_req <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase

      // Reaching the limit ends the game without restarting the timer.
      if (turn_done) begin
        player   <= ~player;
        turn_cnt <= next_cnt;
        if (next_cnt == MAX_CNT) begin
          state <= ST_DONE;
        end else begin
          state         <= ST_TURN;
          timer_restart <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_turn_ctrl.sv
// Bench for turn_ctrl: directed game scenarios plus randomized play against a behavioural model.
module tb_turn_ctrl;
  import game_pkg::*;

  localparam int MAXT = MAX_TURNS_DEFAULT;

  logic clk = 1'b0;
  logic rst, start, move_valid, game_over, timeout, auto_ack;
  logic timer_restart, auto_req, player;
  logic [3:0] turn_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int tr_seen = 0;
  int areq_seen = 0;
  bit cmp_en = 1'b0;

  turn_ctrl #(.MAX_TURNS(MAXT)) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid),
    .game_over(game_over), .timeout(timeout), .auto_ack(auto_ack),
    .timer_restart(timer_restart), .auto_req(auto_req), .player(player),
    .turn_cnt(turn_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural reference: game phase, whose move, turns completed.
  state_t m_st = ST_IDLE;
  bit m_player = 1'b0, m_tr = 1'b0, m_areq = 1'b0;
  int m_cnt = 0;

  always @(posedge clk) begin
    bit completes;
    m_tr = 1'b0;
    if (!rst) begin
      m_st = ST_IDLE; m_player = 1'b0; m_cnt = 0; m_areq = 1'b0;
    end else if (m_st == ST_IDLE || m_st == ST_DONE) begin
      if (start) begin m_st = ST_TURN; m_player = 1'b0; m_cnt = 0; m_tr = 1'b1; end
    end else if (game_over) begin
      m_st = ST_DONE; m_areq = 1'b0;
    end else begin
      completes = (m_st == ST_TURN && move_valid) || (m_st == ST_AUTO && auto_ack);
      if (completes) begin
        m_areq = 1'b0;
        m_player = !m_player;
        m_cnt = (m_cnt + 1 > MAXT) ? MAXT : m_cnt + 1;
        if (m_cnt == MAXT) m_st = ST_DONE;
        else begin m_st = ST_TURN; m_tr = 1'b1; end
      end else if (m_st == ST_TURN && timeout) begin
`ifdef TURN_CTRL_AUTO_MOVE_EN
        m_st = ST_AUTO; m_areq = 1'b1;
`else
        m_player = !m_player; m_tr = 1'b1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (state_o !== 3'(m_st) || player !== m_player || int'(turn_cnt) != m_cnt ||
          timer_restart !== m_tr || auto_req !== m_areq) begin
        errors++;
        $display("FAIL model t=%0t got st=%0d pl=%0d cnt=%0d tr=%0d ar=%0d want st=%0d pl=%0d cnt=%0d tr=%0d ar=%0d",
                 $time, state_o, player, turn_cnt, timer_restart, auto_req,
                 m_st, m_player, m_cnt, m_tr, m_areq);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (timer_restart === 1'b1) tr_seen++;
    if (auto_req === 1'b1) areq_seen++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; move_valid = 1'b0; game_over = 1'b0; timeout = 1'b0; auto_ack = 1'b0;
    step(1);
    cmp_en = 1'b1;
    step(2);
    rst = 1'b1;
    tr_seen = 0; areq_seen = 0;
    step(3);
    chk("reset_state", int'(state_o), int'(ST_IDLE));
    chk("reset_player", int'(player), 0);
    chk("reset_cnt", int'(turn_cnt), 0);
    chk("reset_pulses", tr_seen + areq_seen, 0);

    // Start plus three moves ten cycles apart.
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(9); move_valid = 1'b1; step(1); move_valid = 1'b0;
    end
    step(2);
    chk("moves_restarts", tr_seen, 4);
    chk("moves_player", int'(player), 1);
    chk("moves_cnt", int'(turn_cnt), 3);

    // Simultaneous move and timeout: the move wins.
    areq_seen = 0;
    move_valid = 1'b1; timeout = 1'b1; step(1); move_valid = 1'b0; timeout = 1'b0;
    step(3);
    chk("both_cnt", int'(turn_cnt), 4);
    chk("both_areq", areq_seen, 0);
    chk("both_player", int'(player), 0);

    tr_seen = 0; areq_seen = 0;
    timeout = 1'b1; step(1); timeout = 1'b0;
`ifdef TURN_CTRL_AUTO_MOVE_EN
    step(5); auto_ack = 1'b1; step(1); auto_ack = 1'b0;
    step(2);
    chk("auto_req_cycles", areq_seen, 6);
    chk("auto_player", int'(player), 1);
    chk("auto_cnt", int'(turn_cnt), 5);
    chk("auto_state", int'(state_o), int'(ST_TURN));
    chk("auto_restart", tr_seen, 1);
    // game_over while waiting for the auto move.
    timeout = 1'b1; step(1); timeout = 1'b0;
    step(2);
    game_over = 1'b1; auto_ack = 1'b1; step(1); game_over = 1'b0; auto_ack = 1'b0;
    chk("gover_state", int'(state_o), int'(ST_DONE));
    chk("gover_areq", int'(auto_req), 0);
    chk("gover_cnt", int'(turn_cnt), 5);
`else
    step(2);
    chk("forfeit_player", int'(player), 1);
    chk("forfeit_cnt", int'(turn_cnt), 4);
    chk("forfeit_restart", tr_seen, 1);
    chk("forfeit_areq", areq_seen, 0);
    game_over = 1'b1; move_valid = 1'b1; step(1); game_over = 1'b0; move_valid = 1'b0;
    chk("gover_state", int'(state_o), int'(ST_DONE));
    chk("gover_cnt", int'(turn_cnt), 4);
`endif
    tr_seen = 0;
    step(3);
    chk("done_hold_restart", tr_seen, 0);
    chk("done_hold_state", int'(state_o), int'(ST_DONE));

    // Full game to the turn limit, then a new game.
    start = 1'b1; step(1); start = 1'b0;
    chk("newgame_cnt", int'(turn_cnt), 0);
    for (int i = 0; i < MAXT; i++) begin
      move_valid = 1'b1; step(1); move_valid = 1'b0; step(2);
    end
    step(2);
    chk("limit_state", int'(state_o), int'(ST_DONE));
    chk("limit_cnt", int'(turn_cnt), 9);
    chk("limit_restarts", tr_seen, 9);
    chk("limit_player", int'(player), 1);
    move_valid = 1'b1; step(1); move_valid = 1'b0; step(1);
    chk("limit_saturate", int'(turn_cnt), 9);
    start = 1'b1; step(1); start = 1'b0;
    chk("restart_state", int'(state_o), int'(ST_TURN));
    chk("restart_cnt", int'(turn_cnt), 0);
    chk("restart_player", int'(player), 0);

    // Randomized play, including resets mid-turn and mid-auto.
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 149) != 0);
      start      = ($urandom_range(0, 15) == 0);
      move_valid = ($urandom_range(0, 5) == 0);
      timeout    = ($urandom_range(0, 6) == 0);
      game_over  = ($urandom_range(0, 49) == 0);
      auto_ack   = ($urandom_range(0, 3) == 0);
      step(1);
    end
    rst = 1'b1; start = 1'b0; move_valid = 1'b0; timeout = 1'b0; game_over = 1'b0; auto_ack = 1'b0;
    step(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
